// File: rtl/tx_link_arbiter.sv
// tx_link_arbiter: shares one byte-wide transmit link between NUM_REQ sources.
// Each granted packet is framed as LENGTH, DATA x len, PARITY, then an idle GAP.
// Optional build macro FIXED_PRIO_EN: lowest-index requester always wins and
// the round-robin pointer is removed; without it arbitration is round-robin.
`timescale 1ns/1ps

module tx_link_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter logic [7:0] MAX_LEN    = 8'h14,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [8*NUM_REQ-1:0] Req_len,
    input  logic [8*NUM_REQ-1:0] Req_data,
    output logic [NUM_REQ-1:0]   Grant,
    output logic [NUM_REQ-1:0]   Data_rd,
    output logic [7:0]           Out,
    output logic                 Send_flag,
    output logic                 Busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LENGTH = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] owner;
    logic [7:0]       len_r;
    logic [7:0]       cnt;
    logic [7:0]       gap_cnt;
    logic [11:0]      par_acc;

`ifndef FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    logic [7:0]         len_lane  [NUM_REQ];
    logic [7:0]         data_lane [NUM_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         len_clamped;
    logic [7:0]         cur_data;
    logic               load_data;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;

    // Ones count of one byte, feeding the running parity accumulator.
    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] sum;
        sum = 4'd0;
        for (int k = 0; k < 8; k++) begin
            sum = sum + {3'b000, b[k]};
        end
        return sum;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign len_lane[g]  = Req_len[8*g +: 8];
        assign data_lane[g] = Req_data[8*g +: 8];
    end

    // Pick the winner: first set Req at or after the pointer (or lowest index in fixed mode).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FIXED_PRIO_EN
            cand = i;
`else
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
`endif
            cand_idx = IDX_W'(cand);
            if (!win_found && Req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // One-hot form of the winner and its clamped length, used on the grant edge.
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        len_clamped         = (len_lane[win_idx] > MAX_LEN) ? MAX_LEN : len_lane[win_idx];
        cur_data            = data_lane[owner];
    end

    // A data byte is taken at the next edge from LENGTH (non-empty) or an unfinished DATA cycle.
    always_comb begin
        load_data = ((state == S_LENGTH) && (len_r != 8'd0)) ||
                    ((state == S_DATA) && (cnt < len_r));
        Data_rd   = '0;
        if (load_data) begin
            Data_rd[owner] = 1'b1;
        end
    end

    // Framing state machine with registered link outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            len_r     <= 8'd0;
            cnt       <= 8'd0;
            gap_cnt   <= 8'd0;
            par_acc   <= 12'd0;
            Grant     <= '0;
            Out       <= 8'd0;
            Send_flag <= 1'b0;
            Busy      <= 1'b0;
`ifndef FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    Out       <= 8'd0;
                    Send_flag <= 1'b0;
                    if (win_found) begin
                        state     <= S_LENGTH;
                        owner     <= win_idx;
                        Grant     <= win_onehot;
                        Busy      <= 1'b1;
                        len_r     <= len_clamped;
                        cnt       <= 8'd0;
                        Out       <= len_clamped;
                        Send_flag <= 1'b1;
                        par_acc   <= {8'd0, popcount8(len_clamped)};
                    end
                end
                S_LENGTH, S_DATA: begin
                    if (load_data) begin
                        state   <= S_DATA;
                        Out     <= cur_data;
                        par_acc <= par_acc + {8'd0, popcount8(cur_data)};
                        cnt     <= cnt + 8'd1;
                    end else begin
                        state <= S_PARITY;
                        Out   <= {7'd0, par_acc[0]};
                    end
                end
                S_PARITY: begin
                    state     <= S_GAP;
                    Out       <= 8'd0;
                    Send_flag <= 1'b0;
                    gap_cnt   <= 8'd0;
                end
                S_GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                        Grant <= '0;
                        Busy  <= 1'b0;
`ifndef FIXED_PRIO_EN
                        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_link_arbiter.sv
// tb_tx_link_arbiter: directed, table-driven bench for tx_link_arbiter.
// Sources are modelled as FWFT byte lists that advance after each Data_rd edge.
`timescale 1ns/1ps

module tb_tx_link_arbiter;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req;
    logic [31:0] Req_len;
    logic [31:0] Req_data;
    logic [3:0]  Grant;
    logic [3:0]  Data_rd;
    logic [7:0]  Out;
    logic        Send_flag;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_bytes [4][64];
    int         ptr [4];
    int         rd_cnt [4];
    logic [3:0] rd_latched;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] lens;
        bit          drop;
        int          own_rr;
        int          own_fx;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t vecs [11];
    vec_t rst_vec;
    vec_t post_vec;

    tx_link_arbiter #(
        .NUM_REQ(4),
        .MAX_LEN(8'h14),
        .GAP_CYCLES(2)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Req(Req),
        .Req_len(Req_len),
        .Req_data(Req_data),
        .Grant(Grant),
        .Data_rd(Data_rd),
        .Out(Out),
        .Send_flag(Send_flag),
        .Busy(Busy)
    );

    // Free-running 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic driveData();
        for (int i = 0; i < 4; i++) begin
            Req_data[8*i +: 8] = src_bytes[i][ptr[i]];
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        Req     = v.req;
        Req_len = v.lens;
        for (int i = 0; i < 4; i++) begin
            ptr[i]    = 0;
            rd_cnt[i] = 0;
        end
        rd_latched = 4'b0;
        driveData();
    endtask

    // Advance one clock; sources pop after an edge that saw Data_rd; outputs sampled at negedge.
    task automatic stepCycle();
        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rd_latched[i] && ptr[i] < 63) ptr[i]++;
        end
        driveData();
        @(negedge Clk);
        rd_latched = Data_rd;
        for (int i = 0; i < 4; i++) begin
            if (Data_rd[i]) rd_cnt[i]++;
        end
    endtask

    function automatic int expOwner(input vec_t v);
`ifdef FIXED_PRIO_EN
        return v.own_fx;
`else
        return v.own_rr;
`endif
    endfunction

    // Wait (bounded) for a LENGTH byte; returns cycles waited.
    task automatic waitStart(output int waited);
        waited = 0;
        while (waited < 8) begin
            stepCycle();
            waited++;
            if (Send_flag) break;
        end
    endtask

    task automatic runPacket(input vec_t v, input int tag);
        int         own;
        int         waited;
        int         ones;
        int         others;
        logic [7:0] exp_b;
        own = expOwner(v);
        waitStart(waited);
        checkOutput($sformatf("r%0d_grant_latency", tag), waited, 1);
        if (!Send_flag) begin
            checkOutput($sformatf("r%0d_start_timeout", tag), {31'd0, Send_flag}, 1);
            return;
        end
        checkOutput($sformatf("r%0d_grant", tag), {28'd0, Grant}, {28'd0, 4'b0001 << own});
        checkOutput($sformatf("r%0d_len_byte", tag), {24'd0, Out}, {24'd0, v.exp_len});
        checkOutput($sformatf("r%0d_busy_on", tag), {31'd0, Busy}, 1);
        ones = $countones(v.exp_len);
        for (int k = 0; k < int'(v.exp_len); k++) begin
            stepCycle();
            exp_b = src_bytes[own][k];
            ones  = ones + $countones(exp_b);
            checkOutput($sformatf("r%0d_data%0d", tag, k), {24'd0, Out}, {24'd0, exp_b});
            checkOutput($sformatf("r%0d_send_d%0d", tag, k), {31'd0, Send_flag}, 1);
            if (v.drop && k == 0) Req = Req & ~(4'b0001 << own);
        end
        stepCycle();
        checkOutput($sformatf("r%0d_parity", tag), {24'd0, Out}, ones & 1);
        checkOutput($sformatf("r%0d_send_par", tag), {31'd0, Send_flag}, 1);
        for (int g = 0; g < 2; g++) begin
            stepCycle();
            checkOutput($sformatf("r%0d_gap%0d_send", tag, g), {31'd0, Send_flag}, 0);
            checkOutput($sformatf("r%0d_gap%0d_out", tag, g), {24'd0, Out}, 0);
            checkOutput($sformatf("r%0d_gap%0d_grant", tag, g), {28'd0, Grant}, {28'd0, 4'b0001 << own});
            checkOutput($sformatf("r%0d_gap%0d_busy", tag, g), {31'd0, Busy}, 1);
        end
        stepCycle();
        checkOutput($sformatf("r%0d_idle_busy", tag), {31'd0, Busy}, 0);
        checkOutput($sformatf("r%0d_idle_grant", tag), {28'd0, Grant}, 0);
        checkOutput($sformatf("r%0d_rd_pulses", tag), rd_cnt[own], int'(v.exp_len));
        others = 0;
        for (int i = 0; i < 4; i++) begin
            if (i != own) others = others + rd_cnt[i];
        end
        checkOutput($sformatf("r%0d_rd_others", tag), others, 0);
    endtask

    // Main directed sequence.
    initial begin
        int waited;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 64; k++) begin
                src_bytes[i][k] = 8'((i * 37 + k * 11 + 5) & 255);
            end
        end
        src_bytes[0][0] = 8'hA5;
        src_bytes[0][1] = 8'h0F;
        src_bytes[0][2] = 8'h01;

        //           req      lens          drop rr fx len
        vecs[0]  = '{4'b0001, 32'h00000003, 1'b0, 0, 0, 8'h03};
        vecs[1]  = '{4'b1111, 32'h01010101, 1'b0, 1, 0, 8'h01};
        vecs[2]  = '{4'b1111, 32'h01010101, 1'b0, 2, 0, 8'h01};
        vecs[3]  = '{4'b1111, 32'h01010101, 1'b0, 3, 0, 8'h01};
        vecs[4]  = '{4'b1111, 32'h01010101, 1'b0, 0, 0, 8'h01};
        vecs[5]  = '{4'b0100, 32'h00000000, 1'b0, 2, 2, 8'h00};
        vecs[6]  = '{4'b1000, 32'h30000000, 1'b0, 3, 3, 8'h14};
        vecs[7]  = '{4'b0110, 32'h00020200, 1'b0, 1, 1, 8'h02};
        vecs[8]  = '{4'b0011, 32'h00000202, 1'b0, 0, 0, 8'h02};
        vecs[9]  = '{4'b0010, 32'h00000400, 1'b1, 1, 1, 8'h04};
        vecs[10] = '{4'b0101, 32'h00010001, 1'b0, 2, 0, 8'h01};
        rst_vec  = '{4'b1111, 32'h05050505, 1'b0, 3, 0, 8'h05};
        post_vec = '{4'b1111, 32'h05050505, 1'b0, 0, 0, 8'h05};

        Rst     = 1'b1;
        Req     = 4'b0;
        Req_len = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ptr[i]    = 0;
            rd_cnt[i] = 0;
        end
        rd_latched = 4'b0;
        driveData();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset_out", {24'd0, Out}, 0);
        checkOutput("reset_send", {31'd0, Send_flag}, 0);
        checkOutput("reset_busy", {31'd0, Busy}, 0);
        checkOutput("reset_grant", {28'd0, Grant}, 0);
        Rst = 1'b0;

        for (int c = 0; c < 2; c++) begin
            stepCycle();
            checkOutput($sformatf("idle%0d_out", c), {24'd0, Out}, 0);
            checkOutput($sformatf("idle%0d_send", c), {31'd0, Send_flag}, 0);
            checkOutput($sformatf("idle%0d_busy", c), {31'd0, Busy}, 0);
            checkOutput($sformatf("idle%0d_rd", c), {28'd0, Data_rd}, 0);
        end

        for (int r = 0; r < 11; r++) begin
            applyStimulus(vecs[r]);
            runPacket(vecs[r], r);
        end

        // Reset asserted asynchronously during the second data byte of a 5-byte packet.
        applyStimulus(rst_vec);
        waitStart(waited);
        checkOutput("abort_started", {31'd0, Send_flag}, 1);
        checkOutput("abort_grant", {28'd0, Grant}, {28'd0, 4'b0001 << expOwner(rst_vec)});
        stepCycle();
        stepCycle();
        checkOutput("abort_in_data", {31'd0, Send_flag}, 1);
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("abort_out", {24'd0, Out}, 0);
        checkOutput("abort_send", {31'd0, Send_flag}, 0);
        checkOutput("abort_busy", {31'd0, Busy}, 0);
        checkOutput("abort_grant_clr", {28'd0, Grant}, 0);
        checkOutput("abort_rd", {28'd0, Data_rd}, 0);
        @(posedge Clk);
        #1;
        checkOutput("abort_hold_busy", {31'd0, Busy}, 0);
        @(negedge Clk);
        Rst = 1'b0;
        applyStimulus(post_vec);
        runPacket(post_vec, 99);

        Req = 4'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound so the run always ends even if the DUT stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=%0d expected=%0d", checks, 0);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
